// File: rtl/dec_digits_to_bin.sv
// Serial decimal-to-binary accumulator: takes decimal digits MSD first over a
// valid/ready handshake and presents the rebuilt binary value with valid/ready.
module dec_digits_to_bin #(
  parameter int WIDTH      = 5,
  parameter int MAX_DIGITS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             digit_valid,
  input  logic [3:0]       digit,
  input  logic             digit_last,
  output logic             digit_ready,
  output logic [WIDTH-1:0] value,
  output logic             value_valid,
  input  logic             value_ready,
  output logic             busy,
  output logic             error,
  output logic [1:0]       err_code
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam logic [CW-1:0]      MAX_CNT = CW'(MAX_DIGITS);
  localparam logic [WIDTH+3:0]   MAX_VAL = {4'b0000, {WIDTH{1'b1}}};
  localparam logic [WIDTH+3:0]   TEN     = (WIDTH+4)'(10);

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_OVF     = 2'b10;
  localparam logic [1:0] ERR_EMPTY   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCUM  = 2'b01,
    S_RESULT = 2'b10,
    S_ERROR  = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       err_code_q, err_code_d;
  logic             digit_ready_q, value_valid_q, busy_q, error_q;
  logic [WIDTH+3:0] next_s;

  // Candidate accumulator value, wide enough that acc*10+9 never wraps.
  assign next_s = ({4'b0000, acc_q} * TEN) + {{WIDTH{1'b0}}, digit};

  // Next-state, accumulator and error-code logic.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    err_code_d = err_code_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_ACCUM;
          acc_d      = {WIDTH{1'b0}};
          cnt_d      = {CW{1'b0}};
          err_code_d = ERR_NONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCUM: begin
        // Abort wins over everything; an accompanying digit is dropped.
        if (start) begin
          acc_d = {WIDTH{1'b0}};
          cnt_d = {CW{1'b0}};
        end else if (digit_valid) begin
          if (digit > 4'd9) begin
            state_d    = S_ERROR;
            err_code_d = ERR_ILLEGAL;
          end else if ((next_s > MAX_VAL) || (cnt_q == MAX_CNT)) begin
            state_d    = S_ERROR;
            err_code_d = ERR_OVF;
          end else begin
            acc_d   = next_s[WIDTH-1:0];
            cnt_d   = cnt_q + CW'(1);
            state_d = digit_last ? S_RESULT : S_ACCUM;
          end
        end else if (digit_last) begin
          if (cnt_q != {CW{1'b0}}) begin
            state_d = S_RESULT;
          end else begin
            state_d    = S_ERROR;
            err_code_d = ERR_EMPTY;
          end
        end else begin
          state_d = S_ACCUM;
        end
      end
      S_RESULT: begin
        if (value_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESULT;
        end
      end
      S_ERROR: begin
        if (start) begin
          state_d    = S_ACCUM;
          acc_d      = {WIDTH{1'b0}};
          cnt_d      = {CW{1'b0}};
          err_code_d = ERR_NONE;
        end else begin
          state_d = S_ERROR;
        end
      end
      default: begin
        state_d    = S_IDLE;
        err_code_d = ERR_NONE;
      end
    endcase
  end

  // State and registered outputs; flags are decoded from the next state so
  // they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      acc_q         <= {WIDTH{1'b0}};
      cnt_q         <= {CW{1'b0}};
      err_code_q    <= ERR_NONE;
      digit_ready_q <= 1'b0;
      value_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      err_code_q    <= err_code_d;
      digit_ready_q <= (state_d == S_ACCUM);
      value_valid_q <= (state_d == S_RESULT);
      busy_q        <= (state_d == S_ACCUM) || (state_d == S_RESULT);
      error_q       <= (state_d == S_ERROR);
    end
  end

  assign digit_ready = digit_ready_q;
  assign value       = acc_q;
  assign value_valid = value_valid_q;
  assign busy        = busy_q;
  assign error       = error_q;
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_dec_digits_to_bin.sv
// Scoreboard bench for dec_digits_to_bin: stimulus pushes expected outcomes,
// a negedge monitor pops them on each value handover or error onset.
module tb_dec_digits_to_bin;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, digit_valid, digit_last, value_ready;
  logic [3:0] digit;
  logic       digit_ready, value_valid, busy, error;
  logic [4:0] value;
  logic [1:0] err_code;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       is_err;
    logic [1:0] code;
    logic [4:0] val;
  } exp_t;

  exp_t sb_q[$];
  logic err_prev = 1'b0;

  dec_digits_to_bin #(.WIDTH(5), .MAX_DIGITS(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .digit_valid(digit_valid),
    .digit(digit), .digit_last(digit_last), .digit_ready(digit_ready),
    .value(value), .value_valid(value_valid), .value_ready(value_ready),
    .busy(busy), .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One cycle of input drive, inputs return to idle afterwards.
  task automatic send(input logic s, input logic v, input logic [3:0] d, input logic l);
    start = s; digit_valid = v; digit = d; digit_last = l;
    cyc();
    start = 1'b0; digit_valid = 1'b0; digit = 4'd0; digit_last = 1'b0;
  endtask

  task automatic push_val(input logic [4:0] v);
    exp_t e;
    e.is_err = 1'b0; e.code = 2'b00; e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic push_err(input logic [1:0] c);
    exp_t e;
    e.is_err = 1'b1; e.code = c; e.val = 5'd0;
    sb_q.push_back(e);
  endtask

  // Monitor: compare each observed outcome against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      err_prev = 1'b0;
    end else begin
      if (value_valid && value_ready) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_value", int'(value), -1);
        end else begin
          e = sb_q.pop_front();
          chk("sb_kind_value", 0, int'(e.is_err));
          chk("sb_value", int'(value), int'(e.val));
        end
      end
      if (error && !err_prev) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_error", int'(err_code), -1);
        end else begin
          e = sb_q.pop_front();
          chk("sb_kind_error", 1, int'(e.is_err));
          chk("sb_err_code", int'(err_code), int'(e.code));
        end
      end
      err_prev = error;
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; digit_valid = 1'b0; digit = 4'd0;
    digit_last = 1'b0; value_ready = 1'b0;
    repeat (2) cyc();
    chk("rst_value", int'(value), 0);
    chk("rst_valid", int'(value_valid), 0);
    chk("rst_ready", int'(digit_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_err_code", int'(err_code), 0);
    rst_n = 1'b1;
    cyc();

    // Nominal 3,1 -> 31 (maximum representable value)
    value_ready = 1'b1;
    send(1'b1, 1'b0, 4'd0, 1'b0);
    chk("accum_ready", int'(digit_ready), 1);
    send(1'b0, 1'b1, 4'd3, 1'b0);
    push_val(5'd31);
    send(1'b0, 1'b1, 4'd1, 1'b1);
    chk("nom_latency_valid", int'(value_valid), 1);
    chk("nom_latency_value", int'(value), 31);
    cyc();
    chk("nom_idle_busy", int'(busy), 0);
    chk("nom_idle_valid", int'(value_valid), 0);

    // Overflow 3,2 -> 32, then 7 with a lone last
    send(1'b1, 1'b0, 4'd0, 1'b0);
    send(1'b0, 1'b1, 4'd3, 1'b0);
    push_err(2'b10);
    send(1'b0, 1'b1, 4'd2, 1'b0);
    chk("ovf_error", int'(error), 1);
    chk("ovf_valid", int'(value_valid), 0);
    send(1'b1, 1'b0, 4'd0, 1'b0);
    chk("restart_err_code", int'(err_code), 0);
    send(1'b0, 1'b1, 4'd7, 1'b0);
    push_val(5'd7);
    send(1'b0, 1'b0, 4'd0, 1'b1);
    cyc();

    // Illegal digit, then empty number
    send(1'b1, 1'b0, 4'd0, 1'b0);
    push_err(2'b01);
    send(1'b0, 1'b1, 4'hA, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("illegal_ready_low", int'(digit_ready), 0);
      send(1'b0, 1'b1, 4'd1, 1'b0);
    end
    send(1'b1, 1'b0, 4'd0, 1'b0);
    chk("illegal_cleared", int'(error), 0);
    push_err(2'b11);
    send(1'b0, 1'b0, 4'd0, 1'b1);
    chk("empty_code", int'(err_code), 3);

    // Too many digits: 0,0,5
    send(1'b1, 1'b0, 4'd0, 1'b0);
    send(1'b0, 1'b1, 4'd0, 1'b0);
    send(1'b0, 1'b1, 4'd0, 1'b0);
    chk("two_zeros_ok", int'(error), 0);
    push_err(2'b10);
    send(1'b0, 1'b1, 4'd5, 1'b0);
    chk("too_many_code", int'(err_code), 2);

    // Abort in ACCUM drops the same-cycle digit: 9, start+8, 2, last -> 2
    send(1'b1, 1'b0, 4'd0, 1'b0);
    send(1'b0, 1'b1, 4'd9, 1'b0);
    send(1'b1, 1'b1, 4'd8, 1'b0);
    chk("abort_value", int'(value), 0);
    send(1'b0, 1'b1, 4'd2, 1'b0);
    push_val(5'd2);
    send(1'b0, 1'b0, 4'd0, 1'b1);
    cyc();

    // Backpressure: 1,9 -> 19 held for 5 cycles, start ignored
    value_ready = 1'b0;
    send(1'b1, 1'b0, 4'd0, 1'b0);
    send(1'b0, 1'b1, 4'd1, 1'b0);
    push_val(5'd19);
    send(1'b0, 1'b1, 4'd9, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", int'(value_valid), 1);
      chk("bp_value", int'(value), 19);
      send((i == 2) ? 1'b1 : 1'b0, 1'b0, 4'd0, 1'b0);
    end
    value_ready = 1'b1;
    cyc();
    chk("bp_released", int'(value_valid), 0);

    // Asynchronous reset mid-ACCUM
    send(1'b1, 1'b0, 4'd0, 1'b0);
    send(1'b0, 1'b1, 4'd5, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_value", int'(value), 0);
    chk("arst_ready", int'(digit_ready), 0);
    chk("arst_busy", int'(busy), 0);
    #3;
    rst_n = 1'b1;
    cyc();
    chk("arst_idle_ready", int'(digit_ready), 0);
    send(1'b0, 1'b1, 4'd4, 1'b1);
    chk("idle_ignores_digit", int'(busy), 0);

    repeat (2) cyc();
    chk("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
